latex_fetch_scheduler: RTL and testbench

LATEX_FETCH_SCHEDULER -- requirements
Module: latex_fetch_scheduler

---
 rtl/latex_fetch_scheduler_pkg.sv | 7 +
 rtl/latex_stream_channel.sv | 80 ++++++++
 rtl/latex_fetch_scheduler.sv | 59 +++++
 tb/tb_latex_fetch_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/latex_fetch_scheduler_pkg.sv
// latex_fetch_scheduler_pkg: shared channel state, NUL constant and parameter defaults
package latex_fetch_scheduler_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, FETCH, EMIT_HI, EMIT_LO, DONE} chan_state_t;
  localparam logic [7:0] NUL = 8'h00;
  localparam int MEM_LAT_DEF = 1;
  localparam int MAX_WORDS_DEF = 32;
endpackage

// File: rtl/latex_stream_channel.sv
// latex_stream_channel: one character stream (pointer, word buffer, FSM, valid/ready handshake)
module latex_stream_channel
  import latex_fetch_scheduler_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  ptr_init,
  input  logic        grant,
  input  logic        capture,
  input  logic [15:0] word,
  input  logic        ready,
  output logic        req,
  output logic [7:0]  addr,
  output logic [7:0]  ch,
  output logic        valid,
  output logic        busy,
  output logic        overflow
);
  localparam int CW = $clog2(MAX_WORDS + 1);
  chan_state_t state;
  logic [CW-1:0] words;
  logic [7:0] lo;
  logic last_word;
  assign req = state == WAIT;
  assign busy = state != IDLE && state != DONE;
  assign last_word = words == CW'(MAX_WORDS);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= 8'h00;
      ch <= NUL;
      valid <= 1'b0;
      overflow <= 1'b0;
      words <= '0;
      lo <= NUL;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= WAIT;
          addr <= ptr_init;
          words <= '0;
          overflow <= 1'b0;
        end
        WAIT: if (grant) begin
          state <= FETCH;
          words <= words + 1'b1;
        end
        // a NUL high byte ends the stream before anything is presented
        FETCH: if (capture) begin
          lo <= word[7:0];
          if (word[15:8] == NUL) state <= DONE;
          else begin
            state <= EMIT_HI;
            ch <= word[15:8];
            valid <= 1'b1;
          end
        end
        EMIT_HI: if (ready) begin
          if (lo == NUL) begin
            state <= DONE;
            valid <= 1'b0;
          end else begin
            state <= EMIT_LO;
            ch <= lo;
          end
        end
        EMIT_LO: if (ready) begin
          valid <= 1'b0;
          addr <= addr + 8'd1;
          state <= last_word ? DONE : WAIT;
          overflow <= last_word;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/latex_fetch_scheduler.sv
// latex_fetch_scheduler: two ASCII streams sharing one memory port through a round-robin arbiter
module latex_fetch_scheduler
  import latex_fetch_scheduler_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ptr,
  output logic [7:0]  mem_addr,
  input  logic [15:0] mem_dout,
  output logic [7:0]  lhs_char,
  output logic [7:0]  rhs_char,
  output logic        lhs_valid,
  output logic        rhs_valid,
  input  logic        lhs_ready,
  input  logic        rhs_ready,
  output logic        busy,
  output logic [1:0]  overflow
);
  localparam int LW = $clog2(MEM_LAT + 1);
  logic [LW-1:0] pend;
  logic owner, rhs_last, start_ok, free, g_l, g_r, l_req, r_req, l_busy, r_busy;
  logic [7:0] l_addr, r_addr;
  assign busy = l_busy | r_busy;
  assign start_ok = start & ~busy;
  // the port frees up on the capture edge, so a new grant can overlap it
  assign free = pend <= LW'(1);
  assign g_l = free & l_req & (~r_req | rhs_last);
  assign g_r = free & r_req & ~g_l;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= 8'h00;
      pend <= '0;
      owner <= 1'b0;
      rhs_last <= 1'b1;
    end else begin
      if (g_l | g_r) begin
        mem_addr <= g_l ? l_addr : r_addr;
        owner <= g_r;
        rhs_last <= g_r;
        pend <= LW'(MEM_LAT);
      end else if (pend != '0) pend <= pend - 1'b1;
      if (start_ok) rhs_last <= 1'b1;
    end
  end
  latex_stream_channel #(.MAX_WORDS(MAX_WORDS)) u_lhs (
    .clk(clk), .rst(rst), .start(start_ok), .ptr_init(ptr[15:8]), .grant(g_l),
    .capture(pend == LW'(1) && !owner), .word(mem_dout), .ready(lhs_ready), .req(l_req),
    .addr(l_addr), .ch(lhs_char), .valid(lhs_valid), .busy(l_busy), .overflow(overflow[0])
  );
  latex_stream_channel #(.MAX_WORDS(MAX_WORDS)) u_rhs (
    .clk(clk), .rst(rst), .start(start_ok), .ptr_init(ptr[7:0]), .grant(g_r),
    .capture(pend == LW'(1) && owner), .word(mem_dout), .ready(rhs_ready), .req(r_req),
    .addr(r_addr), .ch(rhs_char), .valid(rhs_valid), .busy(r_busy), .overflow(overflow[1])
  );
endmodule

// File: tb/tb_latex_fetch_scheduler.sv
// tb_latex_fetch_scheduler: directed table, corner sequences and random streams vs a string-walk model
module tb_latex_fetch_scheduler;
  localparam int MAX_WORDS = 32;
  logic clk = 0, rst = 1, start = 0;
  logic [15:0] ptr = 16'h0000;
  logic [7:0] mem_addr, lhs_char, rhs_char;
  logic [15:0] mem_dout;
  logic lhs_valid, rhs_valid, busy;
  logic lhs_ready = 1, rhs_ready = 1;
  logic [1:0] overflow;
  logic [15:0] mem [256];
  int checks = 0, passes = 0;
  bit rand_rdy = 0, l_hold = 0;
  logic [7:0] got_l[$], got_r[$], alog[$], exp_l[$], exp_r[$];
  logic [7:0] prev_addr = 8'h00, pc_l, pc_r;
  logic pv_l = 0, pr_l = 0, pv_r = 0, pr_r = 0, ov_l, ov_r;

  typedef struct {
    logic [15:0] p;
    logic [31:0] ls;
    int ln;
    logic [31:0] rs;
    int rn;
  } vec_t;
  vec_t vt[5];

  assign mem_dout = mem[mem_addr];
  always #5 clk = ~clk;

  latex_fetch_scheduler #(.MEM_LAT(1), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .ptr(ptr), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .lhs_char(lhs_char), .rhs_char(rhs_char), .lhs_valid(lhs_valid), .rhs_valid(rhs_valid),
    .lhs_ready(lhs_ready), .rhs_ready(rhs_ready), .busy(busy), .overflow(overflow)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic logic [31:0] pack(input logic [7:0] q[$]);
    logic [31:0] r = '0;
    foreach (q[i]) r = {r[23:0], q[i]};
    return r;
  endfunction

  task automatic chk_q(input string nm, input logic [7:0] g[$], input logic [7:0] e[$]);
    bit ok;
    ok = g.size() == e.size();
    if (ok) foreach (g[i]) if (g[i] !== e[i]) ok = 0;
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d chars (tail %h) expected %0d chars (tail %h)",
                  nm, g.size(), pack(g), e.size(), pack(e));
  endtask

  // expected stream: walk words from p, stop at the first NUL byte or after MAX_WORDS words
  task automatic model(input logic [7:0] p0, output logic [7:0] q[$], output logic ov);
    logic [7:0] p;
    logic [15:0] w;
    int n;
    p = p0;
    n = 0;
    ov = 0;
    q.delete();
    while (1) begin
      w = mem[p];
      n++;
      if (w[15:8] == 8'h00) break;
      q.push_back(w[15:8]);
      if (w[7:0] == 8'h00) break;
      q.push_back(w[7:0]);
      if (n == MAX_WORDS) begin
        ov = 1;
        break;
      end
      p = p + 8'd1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    lhs_ready = !l_hold && (!rand_rdy || $urandom_range(0, 2) != 0);
    rhs_ready = !rand_rdy || $urandom_range(0, 2) != 0;
  end

  // collects transfers, address changes and checks that a stalled character holds
  always @(negedge clk) begin
    if (rst) begin
      pv_l = 0;
      pv_r = 0;
    end else begin
      if (pv_l && !pr_l) begin
        chk("hold_lhs_valid", lhs_valid, 1);
        chk("hold_lhs_char", lhs_char, pc_l);
      end
      if (pv_r && !pr_r) begin
        chk("hold_rhs_valid", rhs_valid, 1);
        chk("hold_rhs_char", rhs_char, pc_r);
      end
      if (lhs_valid && lhs_ready) got_l.push_back(lhs_char);
      if (rhs_valid && rhs_ready) got_r.push_back(rhs_char);
      if (mem_addr != prev_addr) alog.push_back(mem_addr);
      pv_l = lhs_valid; pr_l = lhs_ready; pc_l = lhs_char;
      pv_r = rhs_valid; pr_r = rhs_ready; pc_r = rhs_char;
    end
    prev_addr = mem_addr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [15:0] p, input bit clr);
    @(posedge clk);
    #2;
    ptr = p;
    start = 1;
    if (clr) begin
      got_l.delete();
      got_r.delete();
      alog.delete();
    end
    @(posedge clk);
    #2;
    start = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", busy, 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_chars"}, {lhs_char, rhs_char}, 0);
    chk({nm, "_valids"}, {lhs_valid, rhs_valid}, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_overflow"}, overflow, 0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 16'h0000;
    mem[8'h10] = 16'h655E; mem[8'h11] = 16'h7400;
    mem[8'h20] = 16'h3173; mem[8'h21] = 16'h0000;
    mem[8'hFF] = 16'h4142; mem[8'h00] = 16'h4300;
    vt[0] = '{16'h1020, 32'h00655E74, 3, 32'h00003173, 2};
    vt[1] = '{16'hFF10, 32'h00414243, 3, 32'h00655E74, 3};
    vt[2] = '{16'h3020, 32'h0, 0, 32'h00003173, 2};
    vt[3] = '{16'h2130, 32'h0, 0, 32'h0, 0};
    vt[4] = '{16'h1111, 32'h74, 1, 32'h74, 1};

    tick(3);
    chk_reset_outputs("reset");
    rst = 0;

    // start-to-first-character latency with both consumers always ready
    pulse(16'h1020, 1);
    chk("lat_e0_mem_addr", mem_addr, 8'h00);
    chk("lat_e0_busy", busy, 1);
    tick(1);
    chk("lat_e1_mem_addr", mem_addr, 8'h10);
    chk("lat_e1_lhs_valid", lhs_valid, 0);
    tick(1);
    chk("lat_e2_lhs", {lhs_valid, lhs_char}, {1'b1, 8'h65});
    chk("lat_e2_mem_addr", mem_addr, 8'h20);
    chk("lat_e2_rhs_valid", rhs_valid, 0);
    tick(1);
    chk("lat_e3_rhs", {rhs_valid, rhs_char}, {1'b1, 8'h31});
    wait_idle();

    rand_rdy = 1;
    for (int i = 0; i < 5; i++) begin
      pulse(vt[i].p, 1);
      wait_idle();
      chk($sformatf("vec%0d_lhs_len", i), got_l.size(), vt[i].ln);
      chk($sformatf("vec%0d_lhs_chars", i), pack(got_l), vt[i].ls);
      chk($sformatf("vec%0d_rhs_len", i), got_r.size(), vt[i].rn);
      chk($sformatf("vec%0d_rhs_chars", i), pack(got_r), vt[i].rs);
      chk($sformatf("vec%0d_overflow", i), overflow, 0);
    end

    // lhs stalled: its first char holds while rhs runs; a start while busy is dropped
    rand_rdy = 0;
    l_hold = 1;
    tick(2);
    pulse(16'h1020, 1);
    tick(12);
    chk("stall_lhs", {lhs_valid, lhs_char}, {1'b1, 8'h65});
    chk("stall_busy", busy, 1);
    chk("stall_rhs_len", got_r.size(), 2);
    chk("stall_rhs_chars", pack(got_r), 32'h3173);
    pulse(16'h4040, 0);
    tick(2);
    l_hold = 0;
    wait_idle();
    chk("stall_lhs_len", got_l.size(), 3);
    chk("stall_lhs_chars", pack(got_l), 32'h655E74);
    chk("busy_start_rhs_len", got_r.size(), 2);

    for (int i = 0; i < 32; i++) mem[8'h40 + i] = {8'h41 + 8'(i), 8'h61 + 8'(i)};
    mem[8'h60] = 16'h5A5A;
    rand_rdy = 1;
    pulse(16'h4020, 1);
    wait_idle();
    model(8'h40, exp_l, ov_l);
    chk("ovf_lhs_len", got_l.size(), 64);
    chk_q("ovf_lhs_stream", got_l, exp_l);
    chk("ovf_flags", overflow, 2'b01);
    pulse(16'h1020, 1);
    chk("ovf_cleared_by_start", overflow, 0);
    wait_idle();

    // reset mid-stream, asserted together with start
    rand_rdy = 0;
    pulse(16'h4020, 1);
    tick(20);
    rst = 1;
    start = 1;
    ptr = 16'h1020;
    tick(1);
    rst = 0;
    start = 0;
    chk_reset_outputs("midrst");
    tick(10);
    chk("midrst_quiet_addr", mem_addr, 8'h00);
    chk("midrst_quiet_busy", busy, 0);

    pulse(16'hFF30, 1);
    wait_idle();
    chk("wrap_addr_count", alog.size(), 3);
    chk("wrap_addr_seq", pack(alog), 32'hFF3000);
    chk("wrap_lhs_chars", pack(got_l), 32'h414243);
    chk("wrap_rhs_len", got_r.size(), 0);

    rand_rdy = 1;
    for (int it = 0; it < 12; it++) begin
      foreach (mem[i]) mem[i] = {($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                                 ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255))};
      ptr = 16'($urandom);
      pulse(ptr, 1);
      wait_idle();
      model(ptr[15:8], exp_l, ov_l);
      model(ptr[7:0], exp_r, ov_r);
      chk_q($sformatf("rand%0d_lhs", it), got_l, exp_l);
      chk_q($sformatf("rand%0d_rhs", it), got_r, exp_r);
      chk($sformatf("rand%0d_overflow", it), overflow, {ov_r, ov_l});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
